uart_rx_ext: RTL

Parametrised next-generation UART receiver. Adds a runtime baud divisor, optional even/odd parity, 1 or 2 stop bits, 3-sample majority voting, start-glitch rejection, error and break flags, and a single-entry valid/ready output register with overrun reporting. Sits between the pad synchroniser-free `uart_rxd` pin and a consumer such as a FIFO or register interface.

---
 rtl/uart_rx_ext.sv | 134 +++++++++++++
 1 files changed

// File: rtl/uart_rx_ext.sv
// uart_rx_ext: UART receiver with runtime divisor, parity, majority voting, break and overrun reporting
//
// Ports:
//   clk, resetn        system clock, asynchronous active-low reset
//   uart_rxd           asynchronous serial input (idles high)
//   uart_rx_en         enables start detection; a frame in flight always completes
//   cfg_div            clock cycles per bit (values below 4 behave as 4), latched at frame start
//   cfg_parity         00/11 none, 01 even, 10 odd, latched at frame start
//   rx_data, rx_valid  received word (LSB first on the line) with valid/ready handshake
//   rx_ready           consumer accepts the held word
//   rx_parity_err      parity mismatch, qualified by rx_valid
//   rx_frame_err       a stop bit was 0, qualified by rx_valid
//   rx_break           all-zero frame including stop bits, qualified by rx_valid
//   rx_overrun         one-cycle pulse when a completed frame is dropped
//   busy               receiver is not idle
module uart_rx_ext #(
   parameter int PAYLOAD_BITS = 8,
   parameter int STOP_BITS    = 1,
   parameter int DIV_W        = 16,
   parameter int SYNC_STAGES  = 2
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    uart_rxd,
   input  logic                    uart_rx_en,
   input  logic [DIV_W-1:0]        cfg_div,
   input  logic [1:0]              cfg_parity,
   output logic [PAYLOAD_BITS-1:0] rx_data,
   output logic                    rx_valid,
   input  logic                    rx_ready,
   output logic                    rx_parity_err,
   output logic                    rx_frame_err,
   output logic                    rx_break,
   output logic                    rx_overrun,
   output logic                    busy
);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK_WAIT} state_t;
   state_t state, nxt;
   logic [SYNC_STAGES-1:0] sync;
   logic rxs;
   logic [DIV_W-1:0] div_q, cnt, half;
   logic [1:0] par_q;
   logic [3:0] bcnt;
   logic s0, s1, bitv, pbit, ferr_acc, stop_zero;
   logic [PAYLOAD_BITS-1:0] shreg;
   logic mid, bit_end, vote, cur_bit, par_en, last_stop, brk, perr, ferr, done;

   assign rxs       = sync[SYNC_STAGES-1];
   assign half      = div_q >> 1;
   assign mid       = cnt == half + DIV_W'(1);
   assign bit_end   = cnt == div_q - DIV_W'(1);
   assign vote      = (s0 & s1) | (s0 & rxs) | (s1 & rxs);
   // with the smallest divisor the vote and the bit end coincide, so use the live vote then
   assign cur_bit   = mid ? vote : bitv;
   assign par_en    = ^par_q;
   assign last_stop = bcnt == 4'(STOP_BITS - 1);
   // the final stop sample is still live when the frame completes, so fold it in here
   assign brk       = ~|shreg & ~(par_en & pbit) & stop_zero & ~vote;
   assign perr      = par_en & (^shreg ^ pbit ^ par_q[1]);
   assign ferr      = ferr_acc | ~vote;
   assign busy      = state != IDLE;

   always_ff @(posedge clk or negedge resetn)
      if (!resetn) state <= IDLE;
      else state <= nxt;

   always_comb begin
      nxt  = state;
      done = 1'b0;
      case (state)
         IDLE:     if (!rxs && uart_rx_en) nxt = START;
         START:    if (mid && vote) nxt = IDLE;
                   else if (bit_end) nxt = DATA;
         DATA:     if (bit_end && bcnt == 4'(PAYLOAD_BITS - 1)) nxt = par_en ? PARITY : STOP;
         PARITY:   if (bit_end) nxt = STOP;
         // completing at the mid-point leaves half a bit of slack for a back-to-back start
         STOP:     if (mid && last_stop) begin
                      done = 1'b1;
                      nxt  = brk ? BRK_WAIT : IDLE;
                   end
         BRK_WAIT: if (rxs) nxt = IDLE;
         default:  nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         sync          <= '1;
         cnt           <= '0;
         div_q         <= '0;
         par_q         <= '0;
         bcnt          <= '0;
         s0            <= 1'b0;
         s1            <= 1'b0;
         bitv          <= 1'b0;
         pbit          <= 1'b0;
         ferr_acc      <= 1'b0;
         stop_zero     <= 1'b0;
         shreg         <= '0;
         rx_data       <= '0;
         rx_valid      <= 1'b0;
         rx_parity_err <= 1'b0;
         rx_frame_err  <= 1'b0;
         rx_break      <= 1'b0;
         rx_overrun    <= 1'b0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], uart_rxd};
         cnt  <= (state == IDLE || state == BRK_WAIT || bit_end) ? '0 : cnt + DIV_W'(1);
         bcnt <= (nxt != state) ? '0 : (bit_end && (state == DATA || state == STOP)) ? bcnt + 4'd1 : bcnt;
         if (state == IDLE && nxt == START) begin
            div_q     <= (cfg_div < DIV_W'(4)) ? DIV_W'(4) : cfg_div;
            par_q     <= cfg_parity;
            ferr_acc  <= 1'b0;
            stop_zero <= 1'b1;
         end
         if (cnt == half - DIV_W'(1)) s0 <= rxs;
         if (cnt == half) s1 <= rxs;
         if (mid) bitv <= vote;
         if (state == DATA && bit_end) shreg <= {cur_bit, shreg[PAYLOAD_BITS-1:1]};
         if (state == PARITY && bit_end) pbit <= cur_bit;
         if (state == STOP && mid) begin
            ferr_acc  <= ferr_acc | ~vote;
            stop_zero <= stop_zero & ~vote;
         end
         rx_overrun <= done && rx_valid && !rx_ready;
         if (done && (!rx_valid || rx_ready)) begin
            rx_valid      <= 1'b1;
            rx_data       <= shreg;
            rx_parity_err <= perr;
            rx_frame_err  <= ferr;
            rx_break      <= brk;
         end else if (rx_ready) rx_valid <= 1'b0;
      end
endmodule
